// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS sweep sequencer and its host-side users.
package dds_pkg;

    localparam int K_W_DEF     = 32;
    localparam int P_W_DEF     = 11;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_TRI  = 1'b1;

    typedef struct packed {
        logic [K_W_DEF-1:0]     start;
        logic [K_W_DEF-1:0]     stop;
        logic [K_W_DEF-1:0]     step;
        logic [DWELL_W_DEF-1:0] dwell;
        logic                   mode;
        logic [P_W_DEF-1:0]     phase;
    } sweep_desc_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep descriptor channel: valid/ready handshake plus the descriptor fields.
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int K_W     = K_W_DEF,
    parameter int P_W     = P_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [K_W-1:0]     cfg_start;
    logic [K_W-1:0]     cfg_stop;
    logic [K_W-1:0]     cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_mode;
    logic [P_W-1:0]     cfg_phase;

    modport master (
        output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/dds_dwell_timer.sv
// Dwell counter: held at zero while clr, counts up while en; expired when count equals dwell.
// Expired is combinational from the registered count; no backpressure.
module dds_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] dwell,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == dwell);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS core: steps K from start toward stop with a per-value dwell.
// Outputs update one cycle after accept/step; cfg_ready only in IDLE, so a new descriptor waits for the sweep.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int K_W     = K_W_DEF,
    parameter int P_W     = P_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    dds_sweep_ctrl_if.slave    cfg,
    input  logic               abort,
    output logic [K_W-1:0]     K,
    output logic [P_W-1:0]     P,
    output logic               k_upd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    state_t             state;
    logic [K_W-1:0]     start_r;
    logic [K_W-1:0]     stop_r;
    logic [K_W-1:0]     step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               mode_r;
    logic               dir_up;
    logic               expired;

    logic [K_W:0]       up_sum;
    logic [K_W:0]       dn_diff;
    logic [K_W-1:0]     up_val;
    logic [K_W-1:0]     dn_val;
    logic               at_end;
    logic               go_up;
    logic [K_W-1:0]     nxt_k;

    assign cfg.cfg_ready = (state == IDLE);

    dds_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != DWELL),
        .en      (state == DWELL),
        .dwell   (dwell_r),
        .expired (expired)
    );

    // Clamp arithmetic is one bit wider so carry/borrow pin K to the sweep bounds.
    always_comb begin
        up_sum  = {1'b0, K} + {1'b0, step_r};
        dn_diff = {1'b0, K} - {1'b0, step_r};
        up_val  = (up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[K_W-1:0];
        dn_val  = (dn_diff[K_W] || (dn_diff[K_W-1:0] <= start_r)) ? start_r : dn_diff[K_W-1:0];
        at_end  = dir_up ? (K == stop_r) : (K == start_r);
        go_up   = at_end ? ~dir_up : dir_up;
        nxt_k   = go_up ? up_val : dn_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_r <= '0;
            stop_r  <= '0;
            step_r  <= '0;
            dwell_r <= '0;
            mode_r  <= MODE_RAMP;
            dir_up  <= 1'b1;
            K       <= '0;
            P       <= '0;
            k_upd   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            k_upd <= 1'b0;
            done  <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
                K     <= '0;
                k_upd <= (K != '0);
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg.cfg_valid) begin
                            start_r <= cfg.cfg_start;
                            stop_r  <= cfg.cfg_stop;
                            step_r  <= cfg.cfg_step;
                            dwell_r <= cfg.cfg_dwell;
                            mode_r  <= cfg.cfg_mode;
                            dir_up  <= 1'b1;
                            K       <= cfg.cfg_start;
                            P       <= cfg.cfg_phase;
                            k_upd   <= 1'b1;
                            busy    <= 1'b1;
                            cfg_err <= (cfg.cfg_step == '0) || (cfg.cfg_start > cfg.cfg_stop);
                            state   <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (expired) begin
                            // A bad descriptor ends after its first dwell without stepping.
                            if (cfg_err) begin
                                busy  <= 1'b0;
                                done  <= (mode_r == MODE_RAMP);
                                state <= (mode_r == MODE_RAMP) ? DONE : IDLE;
                            end else begin
                                state <= STEP;
                            end
                        end
                    end
                    STEP: begin
                        if (at_end && (mode_r == MODE_RAMP)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            K      <= nxt_k;
                            k_upd  <= (nxt_k != K);
                            dir_up <= go_up;
                            state  <= DWELL;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
